// File: rtl/lfsr_gen_if.sv
// lfsr_gen_if: control inputs and valid/ready word stream of lfsr_gen.
// master = generator side, slave = consumer/controller side.
interface lfsr_gen_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] seed_in;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             lockup;
    logic [WIDTH-1:0] period_len;
    logic             period_done;

    modport master (
        input  en, load, seed_in, dout_ready,
        output dout, dout_valid, lockup,
        output period_len, period_done
    );

    modport slave (
        output en, load, seed_in, dout_ready,
        input  dout, dout_valid, lockup,
        input  period_len, period_done
    );
endinterface

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised LFSR word generator (Fibonacci/Galois), valid/ready out.
// Period tracking is built only when LFSR_PERIOD_EN is defined.
module lfsr_gen #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter bit               MODE  = 1'b0
) (
    input logic        clk,
    input logic        rst,
    lfsr_gen_if.master bus
);

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] eff_seed;
    logic             valid_q;
    logic             lock_q;
    logic             xfer;
    logic             zero;

    assign xfer     = valid_q & bus.dout_ready;
    assign zero     = (state == '0);
    assign eff_seed = (bus.seed_in == '0) ? SEED : bus.seed_in;

    // next-state function of the selected LFSR form
    always_comb begin
        nxt = state;
        if (!MODE)
            nxt = {state[WIDTH-2:0], ^(state & TAPS)};
        else
            nxt = (state >> 1) ^ (state[0] ? TAPS : '0);
    end

    // state, stream valid and lock-up recovery; load beats recovery beats transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= SEED;
            valid_q <= 1'b0;
            lock_q  <= 1'b0;
        end else if (bus.load) begin
            state   <= eff_seed;
            valid_q <= 1'b0;
            lock_q  <= 1'b0;
        end else if (zero) begin
            state   <= SEED;
            valid_q <= 1'b0;
            lock_q  <= 1'b1;
        end else begin
            lock_q <= 1'b0;
            if (xfer) begin
                state   <= nxt;
                valid_q <= bus.en;
            end else begin
                valid_q <= valid_q | bus.en;
            end
        end
    end

    assign bus.dout       = state;
    assign bus.dout_valid = valid_q;
    assign bus.lockup     = lock_q;

`ifdef LFSR_PERIOD_EN
    logic [WIDTH-1:0] seed_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] plen_q;
    logic             pdone_q;

    // count transfers until the state comes back to the active seed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seed_q  <= SEED;
            cnt_q   <= '0;
            plen_q  <= '0;
            pdone_q <= 1'b0;
        end else if (bus.load) begin
            seed_q  <= eff_seed;
            cnt_q   <= '0;
            pdone_q <= 1'b0;
        end else if (zero) begin
            seed_q  <= SEED;
            cnt_q   <= '0;
            pdone_q <= 1'b0;
        end else if (xfer) begin
            if (nxt == seed_q) begin
                plen_q  <= cnt_q + 1'b1;
                cnt_q   <= '0;
                pdone_q <= 1'b1;
            end else begin
                cnt_q   <= cnt_q + 1'b1;
                pdone_q <= 1'b0;
            end
        end else begin
            pdone_q <= 1'b0;
        end
    end

    assign bus.period_len  = plen_q;
    assign bus.period_done = pdone_q;
`else
    assign bus.period_len  = '0;
    assign bus.period_done = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: Fibonacci and Galois lfsr_gen instances driven in lockstep,
// checked against a rule-level reference model.
module tb_lfsr_gen;

    localparam logic [7:0] TAPS_C = 8'hB8;
    localparam logic [7:0] SEED_C = 8'h01;
`ifdef LFSR_PERIOD_EN
    localparam bit PER = 1'b1;
`else
    localparam bit PER = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       load;
    logic       ready;
    logic [7:0] seed_in;

    int total = 0;
    int bad   = 0;

    lfsr_gen_if #(.WIDTH(8)) if_f ();
    lfsr_gen_if #(.WIDTH(8)) if_g ();

    assign if_f.en         = en;
    assign if_f.load       = load;
    assign if_f.seed_in    = seed_in;
    assign if_f.dout_ready = ready;
    assign if_g.en         = en;
    assign if_g.load       = load;
    assign if_g.seed_in    = seed_in;
    assign if_g.dout_ready = ready;

    lfsr_gen #(
        .WIDTH(8), .TAPS(TAPS_C), .SEED(SEED_C), .MODE(1'b0)
    ) dut_f (
        .clk(clk), .rst(rst), .bus(if_f.master)
    );

    lfsr_gen #(
        .WIDTH(8), .TAPS(TAPS_C), .SEED(SEED_C), .MODE(1'b1)
    ) dut_g (
        .clk(clk), .rst(rst), .bus(if_g.master)
    );

    always #5 clk = ~clk;

    logic [7:0] o_d[2];
    logic       o_v[2];
    logic       o_lk[2];
    logic [7:0] o_pl[2];
    logic       o_pd[2];

    assign o_d[0]  = if_f.dout;
    assign o_d[1]  = if_g.dout;
    assign o_v[0]  = if_f.dout_valid;
    assign o_v[1]  = if_g.dout_valid;
    assign o_lk[0] = if_f.lockup;
    assign o_lk[1] = if_g.lockup;
    assign o_pl[0] = if_f.period_len;
    assign o_pl[1] = if_g.period_len;
    assign o_pd[0] = if_f.period_done;
    assign o_pd[1] = if_g.period_done;

    // reference model, index 0 = Fibonacci, 1 = Galois
    logic [7:0] m_st[2];
    bit         m_v[2];
    bit         m_lk[2];
    bit         m_pd[2];
    logic [7:0] m_seed[2];
    int         m_cnt[2];
    logic [7:0] m_pl[2];

    function automatic logic [7:0] adv(input logic [7:0] s, input int mode);
        logic [7:0] r;
        bit fb;
        if (mode == 0) begin
            fb = 1'b0;
            for (int i = 0; i < 8; i++)
                if (TAPS_C[i] && s[i]) fb = ~fb;
            r = {s[6:0], fb};
        end else begin
            r = s >> 1;
            if (s[0]) r = r ^ TAPS_C;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = SEED_C; m_v[k] = 0; m_lk[k] = 0; m_pd[k] = 0;
            m_seed[k] = SEED_C; m_cnt[k] = 0; m_pl[k] = 8'h00;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit x;
            x = m_v[k] && ready;
            m_pd[k] = 0;
            if (load) begin
                m_st[k] = (seed_in == 8'h00) ? SEED_C : seed_in;
                m_v[k] = 0; m_lk[k] = 0;
                m_seed[k] = m_st[k]; m_cnt[k] = 0;
            end else if (m_st[k] == 8'h00) begin
                m_st[k] = SEED_C; m_v[k] = 0; m_lk[k] = 1;
                m_seed[k] = SEED_C; m_cnt[k] = 0;
            end else begin
                m_lk[k] = 0;
                if (x) begin
                    m_st[k] = adv(m_st[k], k);
                    m_v[k] = en;
                    m_cnt[k]++;
                    if (m_st[k] == m_seed[k]) begin
                        m_pd[k] = 1;
                        m_pl[k] = 8'(m_cnt[k]);
                        m_cnt[k] = 0;
                    end
                end else begin
                    m_v[k] = m_v[k] | en;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; en = 0; load = 0; ready = 0; seed_in = 8'h00;
        model_reset();
        #12;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (o_d[k] !== SEED_C) begin
                bad++;
                $display("FAIL reset_dout k=%0d got=%h exp=%h", k, o_d[k], SEED_C);
            end
            total++;
            if (o_v[k] !== 1'b0 || o_lk[k] !== 1'b0) begin
                bad++;
                $display("FAIL reset_flags k=%0d got v=%b lk=%b exp 0 0", k, o_v[k], o_lk[k]);
            end
            total++;
            if (o_pl[k] !== 8'h00 || o_pd[k] !== 1'b0) begin
                bad++;
                $display("FAIL reset_period k=%0d got len=%h done=%b exp 00 0", k, o_pl[k], o_pd[k]);
            end
        end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_sequence();
        logic [7:0] fib_t[5];
        logic [7:0] gal_t[6];
        fib_t = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
        gal_t = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
        en = 1; ready = 1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c < 5) begin
                total++;
                if (o_d[0] !== fib_t[c] || o_v[0] !== 1'b1) begin
                    bad++;
                    $display("FAIL fib_seq c=%0d got=%h v=%b exp=%h v=1", c, o_d[0], o_v[0], fib_t[c]);
                end
            end
            total++;
            if (o_d[1] !== gal_t[c] || o_v[1] !== 1'b1) begin
                bad++;
                $display("FAIL gal_seq c=%0d got=%h v=%b exp=%h v=1", c, o_d[1], o_v[1], gal_t[c]);
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] hold[2];
        ready = 0;
        tick();
        hold[0] = o_d[0];
        hold[1] = o_d[1];
        for (int c = 0; c < 5; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (o_d[k] !== hold[k] || o_v[k] !== 1'b1) begin
                    bad++;
                    $display("FAIL stall_hold k=%0d got=%h v=%b exp=%h v=1", k, o_d[k], o_v[k], hold[k]);
                end
            end
        end
        en = 0; ready = 1;
        tick();
        for (int k = 0; k < 2; k++) begin
            total++;
            if (o_d[k] !== adv(hold[k], k) || o_v[k] !== 1'b0) begin
                bad++;
                $display("FAIL drain_adv k=%0d got=%h v=%b exp=%h v=0", k, o_d[k], o_v[k], adv(hold[k], k));
            end
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            total++;
            if (o_d[k] !== adv(hold[k], k) || o_v[k] !== 1'b0) begin
                bad++;
                $display("FAIL drain_idle k=%0d got=%h v=%b exp=%h v=0", k, o_d[k], o_v[k], adv(hold[k], k));
            end
        end
        ready = 0;
    endtask

    task automatic test_load();
        en = 0; ready = 0; load = 1; seed_in = 8'h00;
        tick();
        load = 0;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (o_d[k] !== SEED_C || o_v[k] !== 1'b0) begin
                bad++;
                $display("FAIL load_zero k=%0d got=%h v=%b exp=%h v=0", k, o_d[k], o_v[k], SEED_C);
            end
        end
        en = 1;
        tick();
        load = 1; seed_in = 8'hA5; ready = 1;
        tick();
        load = 0;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (o_d[k] !== 8'hA5 || o_v[k] !== 1'b0) begin
                bad++;
                $display("FAIL load_xfer k=%0d got=%h v=%b exp=a5 v=0", k, o_d[k], o_v[k]);
            end
        end
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            total++;
            if (o_d[k] !== adv(8'hA5, k) || o_v[k] !== 1'b1) begin
                bad++;
                $display("FAIL load_resume k=%0d got=%h v=%b exp=%h v=1", k, o_d[k], o_v[k], adv(8'hA5, k));
            end
        end
    endtask

    task automatic test_lockup();
        en = 1; ready = 1;
        dut_f.state = 8'h00;
        dut_g.state = 8'h00;
        m_st[0] = 8'h00;
        m_st[1] = 8'h00;
        tick();
        for (int k = 0; k < 2; k++) begin
            total++;
            if (o_lk[k] !== 1'b1 || o_d[k] !== SEED_C || o_v[k] !== 1'b0) begin
                bad++;
                $display("FAIL lockup_hit k=%0d got lk=%b d=%h v=%b exp 1 %h 0", k, o_lk[k], o_d[k], o_v[k], SEED_C);
            end
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            total++;
            if (o_lk[k] !== 1'b0) begin
                bad++;
                $display("FAIL lockup_pulse k=%0d got=%b exp=0", k, o_lk[k]);
            end
        end
    endtask

    task automatic test_period();
        int pulses;
        logic [7:0] len_seen;
        pulses = 0;
        len_seen = 8'h00;
        en = 1; ready = 1; load = 1; seed_in = 8'h01;
        tick();
        load = 0;
        for (int c = 0; c < 270; c++) begin
            tick();
            if (o_pd[0] === 1'b1) begin
                pulses++;
                len_seen = o_pl[0];
            end
            for (int k = 0; k < 2; k++) begin
                total++;
                if (o_pd[k] !== (PER & m_pd[k]) || o_pl[k] !== (PER ? m_pl[k] : 8'h00)) begin
                    bad++;
                    $display("FAIL period_track k=%0d c=%0d got done=%b len=%h exp done=%b len=%h",
                             k, c, o_pd[k], o_pl[k], PER & m_pd[k], PER ? m_pl[k] : 8'h00);
                end
            end
        end
        total++;
        if (pulses !== (PER ? 1 : 0) || len_seen !== (PER ? 8'd255 : 8'd0)) begin
            bad++;
            $display("FAIL period_fib got pulses=%0d len=%0d exp pulses=%0d len=%0d",
                     pulses, len_seen, PER ? 1 : 0, PER ? 255 : 0);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            en = ($urandom_range(0, 3) != 0);
            ready = ($urandom_range(0, 2) != 0);
            load = ($urandom_range(0, 31) == 0);
            seed_in = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            tick();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (o_d[k] !== m_st[k] || o_v[k] !== m_v[k] || o_lk[k] !== m_lk[k]) begin
                    bad++;
                    $display("FAIL random k=%0d c=%0d got d=%h v=%b lk=%b exp d=%h v=%b lk=%b",
                             k, c, o_d[k], o_v[k], o_lk[k], m_st[k], m_v[k], m_lk[k]);
                end
                total++;
                if (o_pd[k] !== (PER & m_pd[k]) || o_pl[k] !== (PER ? m_pl[k] : 8'h00)) begin
                    bad++;
                    $display("FAIL random_period k=%0d c=%0d got done=%b len=%h exp done=%b len=%h",
                             k, c, o_pd[k], o_pl[k], PER & m_pd[k], PER ? m_pl[k] : 8'h00);
                end
            end
        end
        load = 0;
    endtask

    task automatic test_async_reset();
        en = 1; ready = 1; load = 0;
        for (int c = 0; c < 4; c++) tick();
        #2;
        rst = 1;
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (o_d[k] !== SEED_C || o_v[k] !== 1'b0 || o_lk[k] !== 1'b0) begin
                bad++;
                $display("FAIL async_reset k=%0d got d=%h v=%b lk=%b exp %h 0 0", k, o_d[k], o_v[k], o_lk[k], SEED_C);
            end
        end
        model_reset();
        @(negedge clk);
        rst = 0;
        en = 0; ready = 0;
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_stall();
        test_load();
        test_lockup();
        test_period();
        test_random();
        test_async_reset();
        test_sequence();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised pseudo-random word generator built on a linear-feedback shift register. It generalises the team's fixed 8-bit shifter with configurable width, tap mask, Fibonacci or Galois mode, runtime seeding, a valid/ready output stream and lock-up recovery. It sits between test-pattern and scrambler logic and any consumer that pulls one word per handshake.

## Interface
- WIDTH, 8: register width, legal range 3..32.
- TAPS, 8'hB8: WIDTH-bit feedback mask. Bit WIDTH-1 must be set; the default is maximal-length for WIDTH=8.
- SEED, 1: WIDTH-bit non-zero default seed. Used at reset and whenever a zero seed is offered.
- MODE, 0: 0 = Fibonacci, 1 = Galois.
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  generation enable.
- load  input  1  one-cycle seed load strobe.
- seed_in  input  WIDTH  runtime seed, sampled when load=1.
- dout  output  WIDTH  current word; equals internal state.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout.
- lockup  output  1  one-cycle pulse when a zero state is detected and recovered.
- period_len  output  WIDTH  transfers since the last seed (LFSR_PERIOD_EN only).
- period_done  output  1  one-cycle pulse when state returns to the seed (LFSR_PERIOD_EN only).

## Operation
- Next-state function:
  - Fibonacci: fb = XOR-reduce(state & TAPS); next = {state[WIDTH-2:0], fb}.
  - Galois: next = (state >> 1) ^ (state[0] ? TAPS : 0).
- Transfer means dout_valid & dout_ready. A transfer advances state to next exactly once. Without a transfer, state holds.
- dout_valid:
  - Rises the cycle after en=1 is seen while it is 0.
  - Once high, it stays high until a transfer or a load. It never drops because en falls.
  - On a transfer it becomes the value of en in that cycle.
- load: state <= seed_in, or SEED if seed_in==0. dout_valid <= 0. Period tracking restarts.
- load plus transfer in the same cycle: the consumer's handshake completes, but load wins the state update and there is no advance.
- Lock-up: if state==0 (reachable only through a bad TAPS value or an upset), next state is forced to SEED, lockup pulses for 1 cycle, and dout_valid is cleared that cycle.
- Priority: rst > load > lock-up recovery > transfer.

## Timing
- Reset values:
  - state/dout = SEED.
  - dout_valid = 0, lockup = 0.
  - period_len = 0, period_done = 0.
- First word: en asserted in cycle N gives dout_valid=1 in cycle N+1, with dout=SEED.
- Throughput is 1 word/cycle with en and dout_ready held high. The new dout is visible the cycle after each transfer.
- rst mid-stream returns to SEED immediately and asynchronously. There is no partial state.
- All outputs are registered. dout_ready has no combinational path to dout_valid.

## Configuration
- LFSR_PERIOD_EN defined:
  - A WIDTH-bit counter increments per transfer. It clears on rst, on load and on lock-up.
  - When the post-transfer state equals the active seed, period_done pulses for 1 cycle, period_len holds the count, and the counter restarts at 0.
  - period_len is stable between pulses.
- LFSR_PERIOD_EN undefined: the counter and seed copy are not built, and period_len and period_done are tied to 0.

## Test plan
- Fibonacci, WIDTH=8, reset, en=1, dout_ready=1 -> dout sequence 01, 02, 04, 08, 11, with dout_valid=1 from the cycle after en.
- Galois (MODE=1), same stimulus -> dout sequence 01, B8, 5C, 2E, 17, B3.
- dout_ready=0 for 5 cycles mid-stream -> dout and dout_valid held constant. Deassert en and then pulse ready once -> a single advance, after which dout_valid=0.
- load with seed_in=8'h00 -> state=01 (SEED) and dout_valid=0. load with seed_in=8'hA5 during an active transfer -> the next dout is A5, not the advanced value.
- Force state to 0 via hierarchical deposit -> lockup pulses for 1 cycle, and dout=01 on the following cycle.
- LFSR_PERIOD_EN, Fibonacci, WIDTH=8, free run -> period_done pulses after 255 transfers with period_len=255. A rebuild without the macro -> both outputs remain 0.
